// File: rtl/phase_pair_pkg.sv
// Shared types for the two-phase strobe generator: phase relationship and FSM states.
package phase_pair_pkg;

  localparam int DIV_W_DEF = 8;

  typedef enum logic [1:0] {
    MODE_SAME = 2'b00,
    MODE_ANTI = 2'b01,
    MODE_QUAD = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STOP = 2'b10
  } state_e;

endpackage

// File: rtl/phase_pair_gen_if.sv
// Control request and phase-pair outputs of the strobe generator.
interface phase_pair_gen_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic [DIV_W-1:0] div;
  logic [1:0]       mode;
  logic             clk_1;
  logic             clk_2;
  logic             rise_1;
  logic             rise_2;
  logic             fell_2;
  logic             busy;

  modport master (
    output en, div, mode,
    input  clk_1, clk_2, rise_1, rise_2, fell_2, busy
  );

  modport slave (
    input  en, div, mode,
    output clk_1, clk_2, rise_1, rise_2, fell_2, busy
  );
endinterface

// File: rtl/phase_pair_gen_half_period_ctr.sv
// Half-period counter: counts 0..div_s-1 while running, strobes wrap at the end
// and mid at floor(div_s/2). div_s is expected to be at least 1.
module half_period_ctr #(
  parameter int DIV_W = 8
) (
  input  logic             clk0,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] div_s,
  output logic             wrap,
  output logic             mid
);
  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;

  assign wrap = (cnt_r == (div_s - DIV_ONE));
  assign mid  = (cnt_r == (div_s >> 1));

  // Counter: clear has priority, wraps to zero at the end of a half period
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (run) begin
      cnt_r <= wrap ? '0 : (cnt_r + DIV_ONE);
    end else begin
      cnt_r <= cnt_r;
    end
  end
endmodule

// File: rtl/phase_pair_gen.sv
// Two-phase strobe generator: clk_1/clk_2 pair with same/anti/quad relationship,
// clean drain to idle on a clk_1 fall, and registered edge-event pulses.
module phase_pair_gen
  import phase_pair_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input logic             clk0,
  input logic             rst_n,
  phase_pair_gen_if.slave bus
);
  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_e           state_r, state_nx_s;
  mode_e            mode_r, mode_nx_s;
  logic [DIV_W-1:0] div_r, div_nx_s;
  logic             clk_1_r, clk_1_nx_s;
  logic             clk_2_r, clk_2_nx_s;
  logic             rise_1_r, rise_2_r, fell_2_r, busy_r;
  logic             clr_s, wrap_s, mid_s;

  assign clr_s = (state_r == S_IDLE);

  half_period_ctr #(.DIV_W(DIV_W)) u_ctr (
    .clk0  (clk0),
    .rst_n (rst_n),
    .clr   (clr_s),
    .run   (~clr_s),
    .div_s (div_r),
    .wrap  (wrap_s),
    .mid   (mid_s)
  );

  // Next state, shadow capture and phase outputs
  always_comb begin
    state_nx_s = state_r;
    mode_nx_s  = mode_r;
    div_nx_s   = div_r;
    clk_1_nx_s = clk_1_r;
    clk_2_nx_s = clk_2_r;
    case (state_r)
      S_IDLE: begin
        if (bus.en) begin
          state_nx_s = S_RUN;
          div_nx_s   = (bus.div == '0) ? DIV_ONE : bus.div;
          mode_nx_s  = mode_e'(bus.mode);
          clk_1_nx_s = 1'b0;
          clk_2_nx_s = (mode_e'(bus.mode) == MODE_ANTI);
        end else begin
          clk_1_nx_s = 1'b0;
          clk_2_nx_s = 1'b0;
        end
      end
      S_RUN, S_STOP: begin
        clk_1_nx_s = wrap_s ? ~clk_1_r : clk_1_r;
        case (mode_r)
          MODE_ANTI: clk_2_nx_s = ~clk_1_nx_s;
          MODE_QUAD: begin
            // Sampling clk_1 at mid gives the steady-state toggle without an early first edge
            if (div_r == DIV_ONE) begin
              clk_2_nx_s = clk_1_nx_s;
            end else if (mid_s) begin
              clk_2_nx_s = clk_1_r;
            end else begin
              clk_2_nx_s = clk_2_r;
            end
          end
          default: clk_2_nx_s = clk_1_nx_s;
        endcase
        if (wrap_s && clk_1_r && ((state_r == S_STOP) || !bus.en)) begin
          state_nx_s = S_IDLE;
          clk_1_nx_s = 1'b0;
          clk_2_nx_s = 1'b0;
        end else if ((state_r == S_RUN) && !bus.en) begin
          state_nx_s = S_STOP;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
        clk_1_nx_s = 1'b0;
        clk_2_nx_s = 1'b0;
      end
    endcase
  end

  // State, shadow and output registers; pulses compare next against current level
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      mode_r   <= MODE_SAME;
      div_r    <= DIV_ONE;
      clk_1_r  <= 1'b0;
      clk_2_r  <= 1'b0;
      rise_1_r <= 1'b0;
      rise_2_r <= 1'b0;
      fell_2_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      mode_r   <= mode_nx_s;
      div_r    <= div_nx_s;
      clk_1_r  <= clk_1_nx_s;
      clk_2_r  <= clk_2_nx_s;
      rise_1_r <= clk_1_nx_s & ~clk_1_r;
      rise_2_r <= clk_2_nx_s & ~clk_2_r;
      fell_2_r <= ~clk_2_nx_s & clk_2_r;
      busy_r   <= (state_nx_s != S_IDLE);
    end
  end

  assign bus.clk_1  = clk_1_r;
  assign bus.clk_2  = clk_2_r;
  assign bus.rise_1 = rise_1_r;
  assign bus.rise_2 = rise_2_r;
  assign bus.fell_2 = fell_2_r;
  assign bus.busy   = busy_r;

  a_same_rise: assert property (@(posedge clk0) disable iff (!rst_n)
    (((mode_r == MODE_SAME) || (mode_r == MODE_RSVD)) && rise_1_r) |-> rise_2_r);

  a_anti_rise: assert property (@(posedge clk0) disable iff (!rst_n)
    ((mode_r == MODE_ANTI) && rise_1_r) |-> fell_2_r);

  a_idle_quiet: assert property (@(posedge clk0) disable iff (!rst_n)
    !busy_r |-> (!clk_1_r && !clk_2_r));
endmodule

// File: tb/tb_phase_pair_gen.sv
// Directed bench for phase_pair_gen: per-cycle vector table plus hand-written
// latency, drain and asynchronous-reset sequences.
module tb_phase_pair_gen;
  import phase_pair_pkg::*;

  localparam int DIV_W = 8;

  typedef struct {
    string      seg;
    logic       en;
    logic [7:0] div;
    logic [1:0] mode;
    logic [5:0] exp;  // {clk_1, clk_2, rise_1, rise_2, fell_2, busy}
  } vec_t;

  logic clk0 = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  phase_pair_gen_if #(.DIV_W(DIV_W)) bus ();

  phase_pair_gen #(.DIV_W(DIV_W)) dut (
    .clk0  (clk0),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk0 = ~clk0;

  function automatic logic [5:0] obs();
    return {bus.clk_1, bus.clk_2, bus.rise_1, bus.rise_2, bus.fell_2, bus.busy};
  endfunction

  function automatic void add(input string seg, input logic e, input logic [7:0] d,
                              input logic [1:0] m, input logic [5:0] x, input int n);
    for (int k = 0; k < n; k++) vecs.push_back('{seg, e, d, m, x});
  endfunction

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: outputs c1,c2,r1,r2,f2,busy = %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int cyc;

    // same, div 3; div/mode changes mid-run ignored; re-request during STOP ignored
    add("A", 1'b1, 8'd3, 2'd0, 6'b000001, 3);
    add("A", 1'b1, 8'd3, 2'd0, 6'b111101, 1);
    add("A", 1'b1, 8'd7, 2'd1, 6'b110001, 2);
    add("A", 1'b1, 8'd7, 2'd1, 6'b000011, 1);
    add("A", 1'b1, 8'd7, 2'd1, 6'b000001, 2);
    add("A", 1'b1, 8'd7, 2'd1, 6'b111101, 1);
    add("A", 1'b0, 8'd3, 2'd0, 6'b110001, 1);
    add("A", 1'b1, 8'd3, 2'd0, 6'b110001, 1);
    add("A", 1'b1, 8'd3, 2'd0, 6'b000010, 1);
    add("A", 1'b0, 8'd3, 2'd0, 6'b000000, 1);
    // anti, div 4
    add("B", 1'b1, 8'd4, 2'd1, 6'b010101, 1);
    add("B", 1'b1, 8'd4, 2'd1, 6'b010001, 3);
    add("B", 1'b1, 8'd4, 2'd1, 6'b101011, 1);
    add("B", 1'b1, 8'd4, 2'd1, 6'b100001, 3);
    add("B", 1'b1, 8'd4, 2'd1, 6'b010101, 1);
    add("B", 1'b1, 8'd4, 2'd1, 6'b010001, 3);
    add("B", 1'b1, 8'd4, 2'd1, 6'b101011, 1);
    add("B", 1'b0, 8'd4, 2'd1, 6'b100001, 3);
    add("B", 1'b0, 8'd4, 2'd1, 6'b000000, 2);
    // quad, div 4: clk_2 lags clk_1 by 3; fell_2 on the STOP -> IDLE edge
    add("C", 1'b1, 8'd4, 2'd2, 6'b000001, 4);
    add("C", 1'b1, 8'd4, 2'd2, 6'b101001, 1);
    add("C", 1'b1, 8'd4, 2'd2, 6'b100001, 2);
    add("C", 1'b1, 8'd4, 2'd2, 6'b110101, 1);
    add("C", 1'b1, 8'd4, 2'd2, 6'b010001, 3);
    add("C", 1'b1, 8'd4, 2'd2, 6'b000011, 1);
    add("C", 1'b1, 8'd4, 2'd2, 6'b101001, 1);
    add("C", 1'b0, 8'd4, 2'd2, 6'b100001, 2);
    add("C", 1'b0, 8'd4, 2'd2, 6'b110101, 1);
    add("C", 1'b0, 8'd4, 2'd2, 6'b000010, 1);
    add("C", 1'b0, 8'd4, 2'd2, 6'b000000, 1);
    // div 0 same: toggle every cycle; en drop on a clk_1 fall goes straight to IDLE
    add("D", 1'b1, 8'd0, 2'd0, 6'b000001, 1);
    add("D", 1'b1, 8'd0, 2'd0, 6'b111101, 1);
    add("D", 1'b1, 8'd0, 2'd0, 6'b000011, 1);
    add("D", 1'b1, 8'd0, 2'd0, 6'b111101, 1);
    add("D", 1'b0, 8'd0, 2'd0, 6'b000010, 1);
    add("D", 1'b0, 8'd0, 2'd0, 6'b000000, 1);
    // div 1 quad behaves as same
    add("E", 1'b1, 8'd1, 2'd2, 6'b000001, 1);
    add("E", 1'b1, 8'd1, 2'd2, 6'b111101, 1);
    add("E", 1'b1, 8'd1, 2'd2, 6'b000011, 1);
    add("E", 1'b1, 8'd1, 2'd2, 6'b111101, 1);
    add("E", 1'b0, 8'd1, 2'd2, 6'b000010, 1);
    add("E", 1'b0, 8'd1, 2'd2, 6'b000000, 1);
    // div 0 anti, en dropped while clk_1 low
    add("F", 1'b1, 8'd0, 2'd1, 6'b010101, 1);
    add("F", 1'b1, 8'd0, 2'd1, 6'b101011, 1);
    add("F", 1'b1, 8'd0, 2'd1, 6'b010101, 1);
    add("F", 1'b0, 8'd0, 2'd1, 6'b101011, 1);
    add("F", 1'b0, 8'd0, 2'd1, 6'b000000, 2);
    // same, div 5: drop en mid-high, re-request in STOP ignored
    add("G", 1'b1, 8'd5, 2'd0, 6'b000001, 5);
    add("G", 1'b1, 8'd5, 2'd0, 6'b111101, 1);
    add("G", 1'b1, 8'd5, 2'd0, 6'b110001, 1);
    add("G", 1'b0, 8'd5, 2'd0, 6'b110001, 1);
    add("G", 1'b1, 8'd5, 2'd0, 6'b110001, 2);
    add("G", 1'b1, 8'd5, 2'd0, 6'b000010, 1);
    add("G", 1'b0, 8'd5, 2'd0, 6'b000000, 1);

    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.div  = 8'd0;
    bus.mode = 2'd0;
    step();
    step();
    check6("reset", obs(), 6'b000000);
    rst_n = 1'b1;
    step();
    check6("idle_after_reset", obs(), 6'b000000);

    foreach (vecs[i]) begin
      bus.en   = vecs[i].en;
      bus.div  = vecs[i].div;
      bus.mode = vecs[i].mode;
      step();
      check6($sformatf("%s_v%0d", vecs[i].seg, i), obs(), vecs[i].exp);
    end

    // quad div 2: first rise after 2 edges, clk_2 lags by 2, drain takes 4 edges
    bus.en   = 1'b1;
    bus.div  = 8'd2;
    bus.mode = 2'd2;
    step();
    cyc = 0;
    while (!bus.rise_1 && cyc < 20) begin
      step();
      cyc++;
    end
    check_int("quad2_first_rise", cyc, 2);
    cyc = 0;
    while (!bus.rise_2 && cyc < 20) begin
      step();
      cyc++;
    end
    check_int("quad2_lag", cyc, 2);
    bus.en = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 20) begin
      step();
      cyc++;
    end
    check_int("quad2_stop_latency", cyc, 4);
    check6("quad2_after_stop", obs(), 6'b000000);

    // asynchronous reset mid-RUN with clk_2 high
    bus.en   = 1'b1;
    bus.div  = 8'd3;
    bus.mode = 2'd1;
    step();
    step();
    check6("pre_reset_run", obs(), 6'b010001);
    #2;
    rst_n = 1'b0;
    #1;
    check6("async_reset", obs(), 6'b000000);
    bus.en = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check6($sformatf("post_reset_idle%0d", k), obs(), 6'b000000);
    end
    bus.en = 1'b1;
    step();
    check6("restart_anti", obs(), 6'b010101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
